dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 21 ++
 rtl/dmem_arbiter_starve_cnt.sv | 35 +++
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: default widths,
// arbitration state encoding and the read-owner tag encoding.
package dmem_arbiter_pkg;

    localparam int DMEM_DATA_W  = 32;
    localparam int DMEM_ADDR_W  = 32;
    // Wide enough for the largest legal starvation limit (15).
    localparam int STARVE_CNT_W = 4;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DMA_FORCE = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_cnt.sv
// Counts consecutive cycles in which the DMA port asks for the RAM but is
// refused. limit_hit fires on the cycle whose refusal makes the count
// reach STARVE_LIMIT, so the arbiter can force a DMA grant next cycle.
module starve_cnt
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic limit_hit
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_M1 = STARVE_CNT_W'(STARVE_LIMIT - 1);

    logic                    denied;
    logic [STARVE_CNT_W-1:0] cnt_p0;

    assign denied    = dma_req & ~dma_gnt;
    assign limit_hit = denied & (cnt_p0 == LIMIT_M1);

    // Count refused DMA cycles; any grant or withdrawn request restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (denied) begin
            cnt_p0 <= cnt_p0 + 1'b1;
        end else begin
            cnt_p0 <= '0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous data RAM. The CPU
// pipeline has priority; the DMA/loader port is served when the CPU is
// idle or, after STARVE_LIMIT refused cycles, for one forced cycle.
// Read data returns one cycle after the grant and is steered by a
// registered owner tag.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_stall,
    output logic [DATA_W-1:0] o_cpu_rdata,
    output logic              o_cpu_rvalid,
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_gnt,
    output logic [DATA_W-1:0] o_dma_rdata,
    output logic              o_dma_rvalid,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    output logic              o_ram_we,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    arb_state_t        state_p0;
    owner_t            tag_p1;
    logic              cpu_grant;
    logic              dma_grant;
    logic              cpu_own;
    logic              dma_own;
    logic              starve_hit;
    logic              cpu_vld_p1;
    logic              dma_vld_p1;
    logic [DATA_W-1:0] cpu_rdata_p1;
    logic [DATA_W-1:0] dma_rdata_p1;

    starve_cnt #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (i_clk),
        .rst      (i_rst),
        .dma_req  (i_dma_req),
        .dma_gnt  (dma_own),
        .limit_hit(starve_hit)
    );

    // Grant decision from current requests and arbitration state; a forced
    // DMA cycle falls back to the CPU if DMA has withdrawn its request.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        unique case (state_p0)
            CPU_PRI: begin
                cpu_grant = i_cpu_req;
                dma_grant = ~i_cpu_req;
            end
            DMA_FORCE: begin
                cpu_grant = ~i_dma_req;
                dma_grant = 1'b1;
            end
            default: begin
                cpu_grant = i_cpu_req;
                dma_grant = ~i_cpu_req;
            end
        endcase
    end

    assign cpu_own     = i_cpu_req & cpu_grant;
    assign dma_own     = i_dma_req & dma_grant;
    assign o_cpu_stall = i_cpu_req & ~cpu_grant;
    assign o_dma_gnt   = dma_own;

    // Arbitration FSM: one forced DMA cycle after the starvation limit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_p0 <= CPU_PRI;
        end else begin
            unique case (state_p0)
                CPU_PRI:   state_p0 <= starve_hit ? DMA_FORCE : CPU_PRI;
                DMA_FORCE: state_p0 <= CPU_PRI;
                default:   state_p0 <= CPU_PRI;
            endcase
        end
    end

    // Route the owning requester onto the RAM port; idle port drives zeros.
    always_comb begin
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_ram_we    = 1'b0;
        if (cpu_own) begin
            o_ram_addr  = i_cpu_addr;
            o_ram_wdata = i_cpu_wdata;
            o_ram_we    = i_cpu_we;
        end else if (dma_own) begin
            o_ram_addr  = i_dma_addr;
            o_ram_wdata = i_dma_wdata;
            o_ram_we    = i_dma_we;
        end
    end

    // ---- stage p1: RAM read data returns; tag says whose it is ----

    // Remember who issued a read so the returning data can be steered.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tag_p1 <= OWN_NONE;
        end else if (cpu_own & ~i_cpu_we) begin
            tag_p1 <= OWN_CPU;
        end else if (dma_own & ~i_dma_we) begin
            tag_p1 <= OWN_DMA;
        end else begin
            tag_p1 <= OWN_NONE;
        end
    end

    assign cpu_vld_p1 = (tag_p1 == OWN_CPU);
    assign dma_vld_p1 = (tag_p1 == OWN_DMA);

    // Capture the last delivered word per port so rdata holds between reads.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cpu_rdata_p1 <= '0;
            dma_rdata_p1 <= '0;
        end else begin
            if (cpu_vld_p1) cpu_rdata_p1 <= i_ram_rdata;
            if (dma_vld_p1) dma_rdata_p1 <= i_ram_rdata;
        end
    end

    assign o_cpu_rvalid = cpu_vld_p1;
    assign o_dma_rvalid = dma_vld_p1;
    assign o_cpu_rdata  = cpu_vld_p1 ? i_ram_rdata : cpu_rdata_p1;
    assign o_dma_rdata  = dma_vld_p1 ? i_ram_rdata : dma_rdata_p1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small synchronous RAM model.
// Inputs change just after the falling edge; grant-side outputs are
// checked 1 ns later, read-return outputs 1 ns after the rising edge.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, ram_we;
    logic [31:0] cpu_rdata, dma_rdata, ram_addr, ram_wdata;
    logic [31:0] ram_rdata;
    logic        mem_init;
    logic [31:0] mem [0:63];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_LIMIT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .o_cpu_stall(cpu_stall),
        .o_cpu_rdata(cpu_rdata), .o_cpu_rvalid(cpu_rvalid),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_addr(dma_addr),
        .i_dma_wdata(dma_wdata), .o_dma_gnt(dma_gnt),
        .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
        .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .o_ram_we(ram_we),
        .i_ram_rdata(ram_rdata)
    );

    // Synchronous RAM: word at byte address A preloads as 0xC0DE0000 | A.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | (i * 4);
            ram_rdata <= '0;
        end else begin
            if (ram_we) mem[ram_addr[7:2]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:2]];
        end
    end

    task automatic drive(input logic c_req, input logic c_we,
                         input logic [31:0] c_addr, input logic [31:0] c_wdata,
                         input logic d_req, input logic d_we,
                         input logic [31:0] d_addr, input logic [31:0] d_wdata);
        cpu_req = c_req; cpu_we = c_we; cpu_addr = c_addr; cpu_wdata = c_wdata;
        dma_req = d_req; dma_we = d_we; dma_addr = d_addr; dma_wdata = d_wdata;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1; mem_init = 1'b1; idle();
        @(posedge clk); #1;
        mem_init = 1'b0;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL reset_cpu_rvalid got %h want 0", cpu_rvalid); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_dma_rvalid got %h want 0", dma_rvalid); end
        checks++; if (cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
        checks++; if (dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata got %h want 0", dma_rdata); end
        checks++; if (ram_we !== 1'b0 || ram_addr !== 32'h0 || ram_wdata !== 32'h0) begin errors++; $display("FAIL reset_ram_idle got we=%h addr=%h wdata=%h want 0/0/0", ram_we, ram_addr, ram_wdata); end
        @(negedge clk); rst = 1'b0;
        // First arbitration after reset: CPU priority.
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0); #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL first_grant_stall got %h want 0", cpu_stall); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL first_grant_dma_gnt got %h want 0", dma_gnt); end
        @(negedge clk); idle(); #1;
        checks++; if (dma_gnt !== 1'b0 || cpu_stall !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL idle_outputs got gnt=%h stall=%h we=%h want 0/0/0", dma_gnt, cpu_stall, ram_we); end
        @(negedge clk);
    endtask

    task automatic test_cpu_read();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (ram_addr !== 32'h10) begin errors++; $display("FAIL cpu_read_ram_addr got %h want 00000010", ram_addr); end
        checks++; if (cpu_stall !== 1'b0 || ram_we !== 1'b0) begin errors++; $display("FAIL cpu_read_stall_we got %h/%h want 0/0", cpu_stall, ram_we); end
        @(posedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b1) begin errors++; $display("FAIL cpu_read_rvalid got %h want 1", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hC0DE0010) begin errors++; $display("FAIL cpu_read_rdata got %h want c0de0010", cpu_rdata); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_dma_rvalid got %h want 0", dma_rvalid); end
        @(negedge clk); idle();
        @(posedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_read_rvalid_drop got %h want 0", cpu_rvalid); end
        checks++; if (cpu_rdata !== 32'hC0DE0010) begin errors++; $display("FAIL cpu_read_rdata_hold got %h want c0de0010", cpu_rdata); end
        @(negedge clk);
    endtask

    // Both ports requesting from an idle start with limit 4: DMA is forced
    // on cycles 5, 10, 15 and the CPU is stalled exactly then.
    task automatic test_starvation(input int ncyc);
        logic exp;
        for (int c = 1; c <= ncyc; c++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0); #1;
            exp = (c % 5 == 0);
            checks++; if (dma_gnt !== exp) begin errors++; $display("FAIL starve_dma_gnt cycle %0d got %h want %h", c, dma_gnt, exp); end
            checks++; if (cpu_stall !== exp) begin errors++; $display("FAIL starve_cpu_stall cycle %0d got %h want %h", c, cpu_stall, exp); end
            @(negedge clk);
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_write_then_dma_read();
        drive(1'b1, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 32'h20 || ram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_write_port got we=%h addr=%h wdata=%h want 1/20/deadbeef", ram_we, ram_addr, ram_wdata); end
        @(posedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_write_no_rvalid got %h want 0", cpu_rvalid); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0); #1;
        checks++; if (dma_gnt !== 1'b1 || ram_addr !== 32'h20) begin errors++; $display("FAIL dma_read_grant got gnt=%h addr=%h want 1/20", dma_gnt, ram_addr); end
        @(posedge clk); #1;
        checks++; if (dma_rvalid !== 1'b1) begin errors++; $display("FAIL dma_read_rvalid got %h want 1", dma_rvalid); end
        checks++; if (dma_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL dma_read_rdata got %h want deadbeef", dma_rdata); end
        checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL dma_read_cpu_rvalid got %h want 0", cpu_rvalid); end
        @(negedge clk); idle();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b0, 32'h4, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hC0DE0004) begin errors++; $display("FAIL b2b_cpu got rvalid=%h rdata=%h want 1/c0de0004", cpu_rvalid, cpu_rdata); end
        checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL b2b_dma_early got %h want 0", dma_rvalid); end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h8, 32'h0); #1;
        checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL b2b_dma_gnt got %h want 1", dma_gnt); end
        @(posedge clk); #1;
        checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'hC0DE0008) begin errors++; $display("FAIL b2b_dma got rvalid=%h rdata=%h want 1/c0de0008", dma_rvalid, dma_rdata); end
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'hC0DE0004) begin errors++; $display("FAIL b2b_cpu_hold got rvalid=%h rdata=%h want 0/c0de0004", cpu_rvalid, cpu_rdata); end
        @(negedge clk); idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (cpu_stall !== 1'b0 || ram_addr !== 32'h10) begin errors++; $display("FAIL rst_read_grant got stall=%h addr=%h want 0/10", cpu_stall, ram_addr); end
        rst = 1'b1; #1;
        checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata_clear got cpu=%h dma=%h want 0/0", cpu_rdata, dma_rdata); end
        @(posedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got cpu=%h dma=%h want 0/0", cpu_rvalid, dma_rvalid); end
        @(negedge clk); rst = 1'b0; idle();
        @(posedge clk); #1;
        checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL rst_after_release got rvalid=%h rdata=%h want 0/0", cpu_rvalid, cpu_rdata); end
        @(negedge clk);
        // Counter must restart from zero: forced DMA again on cycle 5.
        test_starvation(5);
    endtask

    task automatic test_force_drop();
        for (int c = 1; c <= 4; c++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0);
            @(negedge clk);
        end
        // Forced-DMA cycle, but DMA has withdrawn: CPU takes the port.
        drive(1'b1, 1'b0, 32'hC, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0); #1;
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL drop_cpu_stall got %h want 0", cpu_stall); end
        checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL drop_dma_gnt got %h want 0", dma_gnt); end
        checks++; if (ram_addr !== 32'hC) begin errors++; $display("FAIL drop_ram_addr got %h want 0000000c", ram_addr); end
        @(negedge clk);
        // Back in CPU_PRI with a cleared counter: CPU wins 4 cycles, DMA the 5th.
        for (int c = 1; c <= 5; c++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h4, 32'h0); #1;
            checks++; if (dma_gnt !== (c == 5)) begin errors++; $display("FAIL drop_after_gnt cycle %0d got %h want %h", c, dma_gnt, (c == 5)); end
            @(negedge clk);
        end
        idle();
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_starvation(15);
        test_write_then_dma_read();
        test_back_to_back();
        test_reset_mid_read();
        test_force_drop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
